// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD serial arithmetic unit.
package bcd_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_COMP = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // True when the nibble is a legal decimal digit (0..9).
  function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] i_d);
    return (i_d <= BCD_NINE);
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One decimal digit of addition: a + b + carry-in with the +6 correction.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_cin,
  output logic [DIGIT_W-1:0] o_sum,
  output logic               o_cout
);

  logic [DIGIT_W:0]   w_bin;
  logic [DIGIT_W-1:0] w_corr;

  assign w_bin  = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_cin};
  assign o_cout = (w_bin > 5'd9);
  // Only the low nibble survives the correction, so a 4-bit add is enough.
  assign w_corr = w_bin[DIGIT_W-1:0] + BCD_CORR;
  assign o_sum  = o_cout ? w_corr : w_bin[DIGIT_W-1:0];

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, LSD first, one digit per clock.
// Subtraction adds the 9's complement of B; a negative result is turned into
// a magnitude by a second 10's-complement pass over the sum.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  OP,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  CIN,
  output logic [4*DIGITS-1:0]   S,
  output logic                  SIGN,
  output logic                  COUT,
  output logic                  ERR,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op;
  logic               r_carry;
  logic               r_err;
  logic [W-1:0]       r_s;
  logic               r_sign;
  logic               r_cout;
  logic               r_err_out;
  logic               r_busy;
  logic               r_done;

  logic               w_invalid;
  logic [DIGIT_W-1:0] w_add_a;
  logic [DIGIT_W-1:0] w_add_b;
  logic [DIGIT_W-1:0] w_digit;
  logic               w_cout;
  logic [W-1:0]       w_sum_next;
  logic               w_last;

  // Flag any non-decimal nibble in the operands presented with START.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(A[i*DIGIT_W +: DIGIT_W]) || !is_bcd_digit(B[i*DIGIT_W +: DIGIT_W]))
        w_invalid = 1'b1;
    end
  end

  // Feed the shared digit adder: operands during ADD, 9 - sum digit during COMP.
  always_comb begin
    w_add_a = r_a[DIGIT_W-1:0];
    w_add_b = r_op ? (BCD_NINE - r_b[DIGIT_W-1:0]) : r_b[DIGIT_W-1:0];
    if (r_state == ST_COMP) begin
      w_add_a = BCD_NINE - r_sum[DIGIT_W-1:0];
      w_add_b = '0;
    end
  end

  bcd_digit_adder u_digit_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (r_carry),
    .o_sum  (w_digit),
    .o_cout (w_cout)
  );

  // Result register shifts right; the new digit enters at the MSD end.
  assign w_sum_next = (r_sum >> DIGIT_W) | (W'(w_digit) << (W - DIGIT_W));
  assign w_last     = (r_cnt == CNT_W'(DIGITS - 1));

  // Control FSM, working shift registers and registered outputs.
  // NOTE: state is updated with non-blocking assignments only, so every
  // right-hand side sees the values from before this clock edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // NOTE: working registers are reset too; they are cheap flops, not a RAM.
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_op      <= 1'b0;
      r_carry   <= 1'b0;
      r_err     <= 1'b0;
      r_s       <= '0;
      r_sign    <= 1'b0;
      r_cout    <= 1'b0;
      r_err_out <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FIN: begin
          r_state <= ST_IDLE;
          if (START) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= OP;
            r_carry <= OP ? ~CIN : CIN;
            r_err   <= w_invalid;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_a     <= r_a >> DIGIT_W;
          r_b     <= r_b >> DIGIT_W;
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt <= '0;
            if (r_op && !w_cout && !r_err) begin
              // Borrow out of a subtraction: the sum is 10^N - |result|.
              r_carry <= 1'b1;
              r_state <= ST_COMP;
            end else begin
              r_state   <= ST_FIN;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_s       <= r_err ? '0 : w_sum_next;
              r_cout    <= r_err ? 1'b0 : w_cout;
              r_sign    <= 1'b0;
              r_err_out <= r_err;
            end
          end
        end
        ST_COMP: begin
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt     <= '0;
            r_state   <= ST_FIN;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_s       <= w_sum_next;
            r_cout    <= 1'b0;
            r_sign    <= 1'b1;
            r_err_out <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign S    = r_s;
  assign SIGN = r_sign;
  assign COUT = r_cout;
  assign ERR  = r_err_out;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Digit-serial, parametrised packed-BCD adder/subtractor; processes one decimal digit per clock, LSD first.
- Subtraction uses 10's complement and returns a sign-magnitude result. A negative result gets an automatic second complement pass.
- Successor to the fixed 8-digit combinational BCD subtractor. Adds operand width parameter, add/sub mode, borrow/carry chaining, invalid-digit detection and a start/done handshake.
- Sits in the datapath as the shared decimal arithmetic unit for the calculator core.

Parameters:
- DIGITS, 8, number of BCD digits per operand (minimum 1); data width is 4*DIGITS.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  reset; asynchronous, active-high.
- START  in  1  request; sampled only when BUSY=0.
- OP  in  1  0 = add, 1 = subtract; captured with START.
- A  in  4*DIGITS  packed BCD minuend/addend; captured with START.
- B  in  4*DIGITS  packed BCD subtrahend/addend; captured with START.
- CIN  in  1  add: carry-in; sub: borrow-in; captured with START.
- S  out  4*DIGITS  result magnitude, packed BCD.
- SIGN  out  1  1 = negative result (sub only).
- COUT  out  1  add: decimal carry-out; sub: 1 = no borrow (A >= B+CIN).
- ERR  out  1  a captured A or B nibble was > 9.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle pulse; results valid from this cycle.

Behaviour:
- Reset (async, any state): S, SIGN, COUT, ERR, BUSY, DONE = 0; FSM goes to IDLE; digit counter = 0. Reset mid-operation aborts the operation with no DONE.
- States: IDLE, ADD, COMP, FIN.
- IDLE/FIN: BUSY=0. START=1 captures A, B, OP, CIN, sets ERR_int = (any nibble > 9), clears the counter, and goes to ADD.
- FIN lasts one cycle, DONE=1 there, then IDLE unless START is taken (back-to-back allowed). START while BUSY=1 is ignored, and captured operands do not change.
- ADD, DIGITS cycles, digit i in cycle i:
  - b_i = B_i (add) or 9 - B_i (sub).
  - Initial carry is CIN (add) or ~CIN (sub).
  - Digit sum = A_i + b_i + c. If the binary sum > 9, add 6, set carry and keep the low nibble.
  - After the last digit, end carry = c_N.
- Transition after ADD:
  - If OP=1, c_N=0 and !ERR_int: go to COMP.
  - Otherwise: go to FIN.
- COMP, DIGITS cycles: replaces the sum with its 10's complement, digit-serial (9 - d_i plus incoming carry, initial carry 1, same correction rule).
- Latched at FIN entry:
  - Add: S=sum, COUT=c_N, SIGN=0.
  - Sub: COUT=c_N, SIGN=~c_N, S=sum or complemented sum.
  - ERR_int=1: S=0, SIGN=0, COUT=0, ERR=1.
  - Otherwise ERR=0.
- Outputs hold until the next FIN.
- Latency, with START accepted at cycle t:
  - DONE at t+DIGITS+1 for add, non-negative sub or error.
  - DONE at t+2*DIGITS+1 for a negative sub.
- Boundaries:
  - A=B with CIN=0 in sub gives S=0, SIGN=0, COUT=1; negative zero never occurs.
  - All-9s add with carry wraps modulo 10^DIGITS, COUT=1.
  - DIGITS=1 must work: counter width max(1, clog2(DIGITS)).
- Working registers: operand shift registers shift right by 4 per digit; the result shift register fills from the MSD side.

Decomposition:
- Shared package bcd_pkg: DIGIT_W=4, BCD_NINE=4'd9, BCD_CORR=4'd6, state encoding (IDLE, ADD, COMP, FIN) and the is_bcd_digit function.
- One sub-module, bcd_digit_adder: combinational 4-bit digit + digit + carry-in giving corrected digit + carry-out. It is shared by the ADD and COMP states, with muxed inputs.

Test Plan (DIGITS=8):
- add A=00000123 B=00000877 CIN=0 -> S=00001000, COUT=0, SIGN=0, DONE exactly 9 cycles after START.
- add A=99999999 B=00000001 CIN=0 -> S=00000000, COUT=1; repeat with CIN=1, B=0 -> same result.
- sub A=00001000 B=00000001 CIN=0 -> S=00000999, SIGN=0, COUT=1, latency 9; sub A=B=00004321 -> S=0, SIGN=0, COUT=1.
- sub A=00000005 B=00000012 CIN=0 -> S=00000007, SIGN=1, COUT=0, DONE at 17 cycles; CIN=1 -> S=00000008.
- A=0000000A, add -> ERR=1, S=0, COUT=0, latency 9; next valid operation clears ERR.
- Handshake: START pulsed during ADD is ignored (result reflects the first operands); START in the FIN cycle is accepted back-to-back; RESET asserted 3 cycles into ADD -> all outputs 0 immediately, no DONE, next START runs normally.
